// File: rtl/clk_div_prog.sv
// ============================================================================
// Module   : clk_div_prog
// Brief    : Runtime-programmable integer clock divider with programmable
//            high time, glitch-free config apply at period boundaries.
//            Optional macro CLK_DIV_AUTO_DUTY_EN derives high time from div.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_prog #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEF_DIV  = 5,
  parameter int unsigned DEF_HIGH = 3
) (
  input  logic             clk_200mhz,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_val,
  input  logic [CNT_W-1:0] high_val,
  input  logic             load,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             cfg_busy,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] c_ZERO    = '0;
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEF_DIV);
`ifdef CLK_DIV_AUTO_DUTY_EN
  localparam logic [CNT_W-1:0] c_RST_HIGH = CNT_W'((DEF_DIV + 1) / 2);
`else
  localparam logic [CNT_W-1:0] c_RST_HIGH = CNT_W'(DEF_HIGH);
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [CNT_W-1:0] r_div_act,   w_div_act_nxt;
  logic [CNT_W-1:0] r_high_act,  w_high_act_nxt;
  logic [CNT_W-1:0] r_div_pend,  w_div_pend_nxt;
  logic [CNT_W-1:0] r_high_pend, w_high_pend_nxt;
  logic             r_pend,      w_pend_nxt;
  logic             r_cfg_err,   w_cfg_err_nxt;
  logic             r_clk_out,   w_clk_out_nxt;
  logic             r_rise_tick, w_rise_tick_nxt;

  logic             w_boundary;
  logic             w_apply;
  logic             w_load_ok;
  logic [CNT_W-1:0] w_load_high;

`ifdef CLK_DIV_AUTO_DUTY_EN
  // (div+1)>>1 written as (div>>1)+lsb so no bit of an extended sum is dropped
  logic w_unused_high;
  assign w_unused_high = ^high_val;
  assign w_load_high   = {1'b0, div_val[CNT_W-1:1]} + {{(CNT_W-1){1'b0}}, div_val[0]};
  assign w_load_ok     = (div_val >= c_TWO);
`else
  assign w_load_high   = high_val;
  assign w_load_ok     = (div_val >= c_TWO) && (high_val >= c_ONE) && (high_val < div_val);
`endif

  assign w_boundary = (r_state == RUN) && (r_cnt == (r_div_act - c_ONE));

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_div_act_nxt   = r_div_act;
    w_high_act_nxt  = r_high_act;
    w_div_pend_nxt  = r_div_pend;
    w_high_pend_nxt = r_high_pend;
    w_pend_nxt      = r_pend;
    w_cfg_err_nxt   = r_cfg_err;
    w_apply         = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = c_ZERO;
        w_apply   = r_pend;
        if (enable) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_boundary) begin
          w_cnt_nxt = c_ZERO;
          w_apply   = r_pend;
          if (!enable) begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = c_ZERO;
      end
    endcase

    if (w_apply) begin
      w_div_act_nxt  = r_div_pend;
      w_high_act_nxt = r_high_pend;
      w_pend_nxt     = 1'b0;
    end

    // A load in the apply cycle is captured after the apply, so it waits for the next boundary
    if (load) begin
      if (w_load_ok) begin
        w_div_pend_nxt  = div_val;
        w_high_pend_nxt = w_load_high;
        w_pend_nxt      = 1'b1;
        w_cfg_err_nxt   = 1'b0;
      end else begin
        w_cfg_err_nxt   = 1'b1;
      end
    end

    w_clk_out_nxt   = (r_state == RUN) && (r_cnt < r_high_act);
    w_rise_tick_nxt = (r_state == RUN) && (r_cnt == c_ZERO);
  end

  always_ff @(posedge clk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= c_ZERO;
      r_div_act   <= c_DEF_DIV;
      r_high_act  <= c_RST_HIGH;
      r_div_pend  <= c_DEF_DIV;
      r_high_pend <= c_RST_HIGH;
      r_pend      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_clk_out   <= 1'b0;
      r_rise_tick <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div_act   <= w_div_act_nxt;
      r_high_act  <= w_high_act_nxt;
      r_div_pend  <= w_div_pend_nxt;
      r_high_pend <= w_high_pend_nxt;
      r_pend      <= w_pend_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
      r_clk_out   <= w_clk_out_nxt;
      r_rise_tick <= w_rise_tick_nxt;
    end
  end

  assign clk_out   = r_clk_out;
  assign rise_tick = r_rise_tick;
  assign cfg_busy  = r_pend;
  assign cfg_err   = r_cfg_err;

endmodule

`default_nettype wire

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider with programmable high time, clocked from the 200 MHz DCM output.
- Generates a derived clock (e.g. 40 MHz = divide-by-5, high 3) plus a one-cycle rising-edge tick for logic that stays in the source domain.
- Divide/duty changes load through a shadow register and are applied only at a period boundary, so clk_out never glitches.
- Replaces fixed, hard-coded divide counters in the acquisition clocking path.

Parameters:
- CNT_W, 8, width of counter and of the div_val/high_val configuration words
- DEF_DIV, 5, divide ratio active after reset (must be >= 2)
- DEF_HIGH, 3, high-time cycles active after reset (1 <= DEF_HIGH < DEF_DIV)

Ports:
- clk_200mhz  in  1  source clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; level sensitive
- div_val  in  CNT_W  requested divide ratio, in source cycles per output period
- high_val  in  CNT_W  requested high time, in source cycles
- load  in  1  single-cycle strobe; captures div_val/high_val
- clk_out  out  1  divided clock, registered
- rise_tick  out  1  one-cycle pulse, coincident with each clk_out rising edge
- cfg_busy  out  1  a captured configuration is pending
- cfg_err  out  1  sticky flag: the last load was rejected

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, div_act=DEF_DIV, high_act=DEF_HIGH, pend=0.
  - clk_out=0, rise_tick=0, cfg_busy=0, cfg_err=0.
- Registers:
  - cnt[CNT_W-1:0], active config (div_act, high_act), pending config (div_pend, high_pend), pend flag.
- States:
  - IDLE: cnt held 0; clk_out=0, rise_tick=0.
    - enable=1 -> RUN; the next cycle has cnt=0.
  - RUN: cnt increments by 1 each cycle and wraps div_act-1 -> 0. The wrap cycle is the period boundary.
    - At the boundary with enable=0 -> IDLE. The current period always completes, so there is no runt high pulse.
- Outputs (registered, one cycle after cnt):
  - clk_out = (state==RUN) && (cnt < high_act).
  - rise_tick = (state==RUN) && (cnt==0).
  - Period = div_act cycles; high = high_act cycles; low = div_act-high_act cycles.
- Load validation, in the cycle load=1:
  - Valid means div_val >= 2, high_val >= 1, and high_val < div_val.
  - Valid: div_pend/high_pend <= inputs, pend=1, cfg_err=0.
  - Invalid: pending config unchanged, cfg_err=1 (sticky until the next valid load), cfg_busy unchanged.
- Apply:
  - In RUN, at the boundary cycle with pend=1: active <= pending, pend=0. The new period starts with cnt=0 under the new config.
  - In IDLE with pend=1: applied on the next cycle.
- cfg_busy = pend (registered).
- Simultaneous events:
  - Load on the boundary cycle: capture this cycle; apply at the next boundary.
  - A second valid load while busy overwrites the pending config; only the latest is applied.
  - Enable falling and a pending apply on the same boundary: the apply happens and the block goes to IDLE.
- Reset mid-period forces clk_out low immediately (async). This may truncate a high phase; that is accepted.
- Counter arithmetic is unsigned CNT_W; no overflow is possible because cnt < div_act <= 2^CNT_W-1.

Optional Feature:
- CLK_DIV_AUTO_DUTY_EN defined:
  - high_val is ignored. high_pend = (div_val+1)>>1, i.e. 50% duty for even ratios, one extra high cycle for odd.
  - Validation reduces to div_val >= 2.
  - DEF_HIGH is ignored; the reset value is (DEF_DIV+1)>>1.
- Undefined: behaviour as above; high_val is used and validated.

Test Plan:
- Reset release, enable=1, defaults 5/3 -> clk_out pattern 1,1,1,0,0 repeating (40 MHz); rise_tick every 5th cycle, aligned to the clk_out rise.
- Mid-period load div=8 high=4 -> cfg_busy=1 until the current 5-cycle period ends; next period is 1x4,0x4; no cycle of pattern is shorter than configured.
- Load div=1 or high=0 or high=6 with div=6 -> cfg_err=1, output keeps 5/3. A following valid load (4/2) clears cfg_err and applies 4/2 at the next boundary.
- enable dropped on cnt=1 -> current period finishes (high 3, low 2), then clk_out stays 0. Re-enable -> clk_out high on the second cycle after enable.
- rst_n asserted while clk_out=1 -> clk_out=0, cfg_busy=0, and 5/3 restored without a clock edge.
- With CLK_DIV_AUTO_DUTY_EN, load div=7 -> 4 high, 3 low; load div=6 -> 3/3.
